// File: rtl/conv_window_gen_pkg.sv
// Shared helpers for the sliding-window generator and the conv MAC arrays that
// consume its windows: pixel width, counter widths, window pixel indexing.
package conv_window_gen_pkg;

  function automatic int pix_w(input int dw, input int ch);
    return dw * ch;
  endfunction

  // Degenerate sizes of 1 would give a zero-width counter.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pixel index of window position (r, c); r=0 oldest row, c=0 leftmost column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  typedef struct packed {
    logic vld;
    logic done;
  } out_flags_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / window-stream out bus of the window generator.
interface conv_window_gen_if #(
  parameter int PIX   = 512,
  parameter int KSIZE = 3
);
  logic [PIX-1:0]             Data_In;
  logic                       Valid_In;
  logic [PIX*KSIZE*KSIZE-1:0] Data_Out;
  logic                       Valid_Out;
  logic                       Frame_Done;

  modport master (output Data_In, Valid_In, input Data_Out, Valid_Out, Frame_Done);
  modport slave  (input Data_In, Valid_In, output Data_Out, Valid_Out, Frame_Done);
endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: a circular buffer whose single tap is the pixel
// written DEPTH accepted beats ago. Contents are never cleared.
module conv_window_gen_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH = 44,
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] tap_o
);
  localparam int AW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  // Read-before-write at the same slot yields exactly DEPTH beats of delay.
  assign tap_o = mem_q[ptr_q];
  assign ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst)      ptr_q <= '0;
    else if (en_i) ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (en_i) mem_q[ptr_q] <= din_i;
  end

endmodule

// File: rtl/conv_window_gen.sv
// KSIZE x KSIZE sliding-window generator over a raster pixel stream with
// configurable stride; one registered window per qualifying accepted beat.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 16,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int KSIZE      = 3,
  parameter int STRIDE     = 1
) (
  input  logic            clk,
  input  logic            rst,
  conv_window_gen_if.slave bus
);
  localparam int PIX = pix_w(DATA_WIDHT, CHANNEL);
  localparam int CW  = cnt_w(IMG_WIDHT);
  localparam int RW  = cnt_w(IMG_HEIGHT);
  localparam int SW  = cnt_w(STRIDE);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] cph_q, cph_d, rph_q, rph_d;

  logic [KSIZE-1:0][KSIZE-1:0][PIX-1:0] win_q, win_d, dout_q;
  logic [KSIZE-1:0][PIX-1:0]            col_in;
  out_flags_t                           flags_q, flags_d;

  logic acc, lb_en, col_last, row_last, col_rng, row_rng, emit;

  assign acc   = bus.Valid_In;
  assign lb_en = acc & rst;

  // Newest row comes straight from the input; older rows from the buffer chain.
  assign col_in[KSIZE-1] = bus.Data_In;

  generate
    if (KSIZE > 1) begin : g_lb
      logic [KSIZE-2:0][PIX-1:0] tap;
      for (genvar j = 0; j < KSIZE - 1; j++) begin : g_buf
        logic [PIX-1:0] din;
        if (j == 0) begin : g_head
          assign din = bus.Data_In;
        end else begin : g_chain
          assign din = tap[j-1];
        end
        conv_window_gen_line_buffer #(.DEPTH(IMG_WIDHT), .WIDTH(PIX)) u_lb (
          .clk   (clk),
          .rst   (rst),
          .en_i  (lb_en),
          .din_i (din),
          .tap_o (tap[j])
        );
      end
      for (genvar r = 0; r < KSIZE - 1; r++) begin : g_col
        assign col_in[r] = tap[KSIZE-2-r];
      end
    end
  endgenerate

  assign col_last = (col_q == CW'(IMG_WIDHT - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
  assign col_rng  = (int'(col_q) >= KSIZE - 1);
  assign row_rng  = (int'(row_q) >= KSIZE - 1);
  assign emit     = acc && col_rng && row_rng && (cph_q == '0) && (rph_q == '0);

  // Phase counters sit at 0 until the first window column/row, then count
  // down from STRIDE-1 so a zero phase marks every STRIDE-th position.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (acc) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last || int'(col_q) < KSIZE - 1) cph_d = '0;
      else                                     cph_d = (cph_q == '0) ? SW'(STRIDE - 1) : cph_q - 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
        if (row_last || int'(row_q) < KSIZE - 1) rph_d = '0;
        else                                     rph_d = (rph_q == '0) ? SW'(STRIDE - 1) : rph_q - 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][KSIZE-1] = col_in[r];
    end
  end

  always_comb begin
    flags_d      = '0;
    flags_d.vld  = emit;
    flags_d.done = acc && col_last && row_last;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      flags_q <= '0;
      dout_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      flags_q <= flags_d;
      if (emit) dout_q <= win_d;
    end
  end

  // Window registers are not reset; the counters keep stale contents out.
  always_ff @(posedge clk) begin
    if (lb_en) win_q <= win_d;
  end

  assign bus.Data_Out   = dout_q;
  assign bus.Valid_Out  = flags_q.vld;
  assign bus.Frame_Done = flags_q.done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: four configurations checked against a
// golden window model driven by image coordinates.
module tb_conv_window_gen;
  localparam int ND   = 4;
  localparam int WMAX = 4608;
  localparam int P_K  [ND] = '{3, 3, 1, 3};
  localparam int P_S  [ND] = '{1, 2, 1, 2};
  localparam int P_W  [ND] = '{44, 44, 4, 5};
  localparam int P_H  [ND] = '{44, 44, 4, 5};
  localparam int P_CH [ND] = '{16, 16, 1, 1};

  typedef struct {
    int dut;
    int nframes;
    bit drop;
    int exp_win;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int   cur_r = 0, cur_c = 0, cur_tag = 0, sel = 0, cyc = 0;
  logic vin = 1'b0;
  int   nchk = 0, nerr = 0, bad_rst = 0;
  int   dtag [ND];

  function automatic logic [31:0] word(input int r, input int c, input int ch, input int tag);
    return {8'(r), 8'(c), 16'(ch + (tag << 12))};
  endfunction

  function automatic logic [511:0] pack16(input int r, input int c, input int tag);
    logic [511:0] v;
    v = '0;
    for (int ch = 0; ch < 16; ch++) v[ch*32 +: 32] = word(r, c, ch, tag);
    return v;
  endfunction

  conv_window_gen_if #(.PIX(512), .KSIZE(3)) if_a ();
  conv_window_gen_if #(.PIX(512), .KSIZE(3)) if_b ();
  conv_window_gen_if #(.PIX(32),  .KSIZE(1)) if_c ();
  conv_window_gen_if #(.PIX(32),  .KSIZE(3)) if_d ();

  conv_window_gen #(.DATA_WIDHT(32), .CHANNEL(16), .IMG_WIDHT(44), .IMG_HEIGHT(44), .KSIZE(3), .STRIDE(1))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  conv_window_gen #(.DATA_WIDHT(32), .CHANNEL(16), .IMG_WIDHT(44), .IMG_HEIGHT(44), .KSIZE(3), .STRIDE(2))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  conv_window_gen #(.DATA_WIDHT(32), .CHANNEL(1), .IMG_WIDHT(4), .IMG_HEIGHT(4), .KSIZE(1), .STRIDE(1))
    u_c (.clk(clk), .rst(rst), .bus(if_c));
  conv_window_gen #(.DATA_WIDHT(32), .CHANNEL(1), .IMG_WIDHT(5), .IMG_HEIGHT(5), .KSIZE(3), .STRIDE(2))
    u_d (.clk(clk), .rst(rst), .bus(if_d));

  assign if_a.Data_In  = pack16(cur_r, cur_c, cur_tag);
  assign if_b.Data_In  = pack16(cur_r, cur_c, cur_tag);
  assign if_c.Data_In  = word(cur_r, cur_c, 0, cur_tag);
  assign if_d.Data_In  = word(cur_r, cur_c, 0, cur_tag);
  assign if_a.Valid_In = vin && (sel == 0);
  assign if_b.Valid_In = vin && (sel == 1);
  assign if_c.Valid_In = vin && (sel == 2);
  assign if_d.Valid_In = vin && (sel == 3);

  logic [WMAX-1:0] dout [ND];
  logic [ND-1:0]   vout, fdone, vins, vin_q;
  logic            rst_seen = 1'b0;
  assign dout[0] = if_a.Data_Out;
  assign dout[1] = if_b.Data_Out;
  assign dout[2] = WMAX'(if_c.Data_Out);
  assign dout[3] = WMAX'(if_d.Data_Out);
  assign vout    = {if_d.Valid_Out,  if_c.Valid_Out,  if_b.Valid_Out,  if_a.Valid_Out};
  assign fdone   = {if_d.Frame_Done, if_c.Frame_Done, if_b.Frame_Done, if_a.Frame_Done};
  assign vins    = {if_d.Valid_In,   if_c.Valid_In,   if_b.Valid_In,   if_a.Valid_In};

  // Golden window: bottom-right image pixel (r0, c0), all channels of every tap.
  function automatic logic [WMAX-1:0] exp_win(input int d, input int r0, input int c0, input int tag);
    logic [WMAX-1:0] v;
    int k, pix;
    v = '0;
    k = P_K[d];
    pix = 32 * P_CH[d];
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        for (int ch = 0; ch < P_CH[d]; ch++)
          v[(r*k + c)*pix + ch*32 +: 32] = word(r0 - (k-1) + r, c0 - (k-1) + c, ch, tag);
    return v;
  endfunction

  function automatic int total_win(input int d);
    return ((P_H[d] - P_K[d]) / P_S[d] + 1) * ((P_W[d] - P_K[d]) / P_S[d] + 1);
  endfunction

  function automatic bit last_emits(input int d);
    return ((P_H[d] - P_K[d]) % P_S[d] == 0) && ((P_W[d] - P_K[d]) % P_S[d] == 0);
  endfunction

  int er [ND], ec [ND], ftag [ND], fwin [ND];
  int win_cnt [ND], done_cnt [ND], bad_dat [ND], bad_fd [ND], bad_idle [ND];
  logic [WMAX-1:0] last_out [ND];

  always @(posedge clk) begin
    rst_seen <= !rst;
    vin_q    <= vins;
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst_seen) begin
        er[d] = P_K[d] - 1;  ec[d] = P_K[d] - 1;
        ftag[d] = 0;  fwin[d] = 0;  win_cnt[d] = 0;  done_cnt[d] = 0;
        bad_dat[d] = 0;  bad_fd[d] = 0;  bad_idle[d] = 0;
        last_out[d] = '0;
        if (vout[d] || fdone[d] || dout[d] != '0) bad_rst++;
      end else begin
        if (vout[d]) begin
          if (dout[d] !== exp_win(d, er[d], ec[d], ftag[d])) bad_dat[d]++;
          if (!vin_q[d]) bad_idle[d]++;
          last_out[d] = dout[d];
          win_cnt[d]++;
          fwin[d]++;
          ec[d] += P_S[d];
          if (ec[d] > P_W[d] - 1) begin
            ec[d] = P_K[d] - 1;
            er[d] += P_S[d];
            if (er[d] > P_H[d] - 1) begin
              er[d] = P_K[d] - 1;
              ftag[d] ^= 1;
            end
          end
        end else if (dout[d] !== last_out[d]) begin
          bad_dat[d]++;
        end
        if (fdone[d]) begin
          done_cnt[d]++;
          if (fwin[d] != total_win(d) || vout[d] != last_emits(d)) bad_fd[d]++;
          fwin[d] = 0;
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int d, input int r, input int c, input bit drop);
    if (drop && (cyc % 3 == 2)) begin
      vin = 1'b0;
      step();
      cyc++;
    end
    sel = d;  cur_r = r;  cur_c = c;  cur_tag = dtag[d];
    vin = 1'b1;
    step();
    cyc++;
    vin = 1'b0;
  endtask

  task automatic send_frame(input int d, input bit drop);
    for (int r = 0; r < P_H[d]; r++)
      for (int c = 0; c < P_W[d]; c++)
        send_pix(d, r, c, drop);
    dtag[d] ^= 1;
  endtask

  vec_t vecs [6];
  int b_win, b_done, b_dat, b_fd, b_idle;

  initial begin
    vecs[0] = '{dut: 0, nframes: 1, drop: 1'b0, exp_win: 1764, exp_done: 1};
    vecs[1] = '{dut: 1, nframes: 1, drop: 1'b0, exp_win: 441,  exp_done: 1};
    vecs[2] = '{dut: 0, nframes: 1, drop: 1'b1, exp_win: 1764, exp_done: 1};
    vecs[3] = '{dut: 0, nframes: 2, drop: 1'b0, exp_win: 3528, exp_done: 2};
    vecs[4] = '{dut: 2, nframes: 1, drop: 1'b0, exp_win: 16,   exp_done: 1};
    vecs[5] = '{dut: 3, nframes: 1, drop: 1'b0, exp_win: 4,    exp_done: 1};
    for (int d = 0; d < ND; d++) dtag[d] = 0;

    rst = 1'b0;
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset_vout%0d", d), int'(vout[d]), 0);
      check($sformatf("reset_fdone%0d", d), int'(fdone[d]), 0);
      check($sformatf("reset_dout_zero%0d", d), int'(dout[d] == '0), 1);
    end
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      automatic int d = vecs[i].dut;
      b_win = win_cnt[d];  b_done = done_cnt[d];  b_dat = bad_dat[d];
      b_fd = bad_fd[d];    b_idle = bad_idle[d];
      for (int f = 0; f < vecs[i].nframes; f++) send_frame(d, vecs[i].drop);
      repeat (4) step();
      check($sformatf("v%0d_windows", i), win_cnt[d] - b_win, vecs[i].exp_win);
      check($sformatf("v%0d_frame_done", i), done_cnt[d] - b_done, vecs[i].exp_done);
      check($sformatf("v%0d_data_errs", i), bad_dat[d] - b_dat, 0);
      check($sformatf("v%0d_done_align_errs", i), bad_fd[d] - b_fd, 0);
      check($sformatf("v%0d_vout_after_idle", i), bad_idle[d] - b_idle, 0);
    end

    // Reset lands on the beat carrying pixel (20,10); that beat must be dropped.
    for (int r = 0; r <= 20; r++)
      for (int c = 0; c < 44; c++)
        if (r < 20 || c < 10) send_pix(0, r, c, 1'b0);
    check("pre_reset_vout", int'(if_a.Valid_Out), 1);
    sel = 0;  cur_r = 20;  cur_c = 10;  cur_tag = dtag[0];
    vin = 1'b1;
    rst = 1'b0;
    step();
    vin = 1'b0;
    check("mid_reset_vout", int'(if_a.Valid_Out), 0);
    check("mid_reset_dout_zero", int'(if_a.Data_Out == '0), 1);
    step();
    rst = 1'b1;
    dtag[0] = 0;
    step();
    send_frame(0, 1'b0);
    repeat (4) step();
    check("rst_windows", win_cnt[0], 1764);
    check("rst_frame_done", done_cnt[0], 1);
    check("rst_data_errs", bad_dat[0], 0);
    check("rst_done_align_errs", bad_fd[0], 0);
    check("rst_output_while_reset", bad_rst, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
